// File: rtl/btn_debounce_bank.sv
// Multi-channel push-button debouncer with a 2-flop synchroniser, polarity fix-up, press/release pulses
// and optional hold auto-repeat (define BTN_REPEAT_EN). "release"/"repeat" are keywords, hence the _pulse names.
module btn_debounce_bank #(
  parameter int                  CHANNELS      = 4,
  parameter int                  CNT_DEPTH     = 104857,
  parameter logic [CHANNELS-1:0] POLARITY      = '0,
  parameter int                  REPEAT_DELAY  = 50000000,
  parameter int                  REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  localparam int               CNT_W    = $clog2(CNT_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_DEPTH - 1);

  if (CHANNELS < 1 || CNT_DEPTH < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("btn_debounce_bank: all size/timing parameters must be >= 1");
  end

  logic [CHANNELS-1:0] sync1, sync2, norm;
  logic [CHANNELS-1:0] done, rise, fall;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  // Sync flops reset to the idle pin level so the normalised input starts inactive.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= POLARITY;
      sync2 <= POLARITY;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign norm = sync2 ^ POLARITY;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    done = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      done[i] = (norm[i] != level[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = done & norm;
  assign fall = done & ~norm;

  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset element by element.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (norm[i] == level[i] || done[i]) cnt[i] <= '0;
        else                                cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      any_press     <= 1'b0;
    end else begin
      level         <= level ^ done;
      press         <= rise;
      release_pulse <= fall;
      any_press     <= |rise;
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int                HOLD_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int                HOLD_W      = $clog2(HOLD_MAX) + 1;
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0]   hold [CHANNELS];
  logic [CHANNELS-1:0] in_period, fire;

  // The hold counter restarts after each repeat, so it only ever reaches the current target.
  always_comb begin
    fire = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fire[i] = level[i] && !done[i] &&
                (hold[i] == (in_period[i] ? PERIOD_LAST : DELAY_LAST));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHANNELS; i++) hold[i] <= '0;
      in_period    <= '0;
      repeat_pulse <= '0;
    end else begin
      repeat_pulse <= fire;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!level[i] || done[i]) begin
          hold[i]      <= '0;
          in_period[i] <= 1'b0;
        end else if (fire[i]) begin
          hold[i]      <= '0;
          in_period[i] <= 1'b1;
        end else begin
          hold[i]      <= hold[i] + 1'b1;
        end
      end
    end
  end
`else
  assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: directed phases plus random pin activity,
// every cycle compared against a sliding-window model of the debounce rules.
module tb_btn_debounce_bank;

  localparam int         CH  = 2;
  localparam int         CD  = 4;
  localparam logic [1:0] POL = 2'b10;
  localparam int         RD  = 8;
  localparam int         RP  = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [CH-1:0] raw_in = POL;
  logic [CH-1:0] level, press, release_pulse, repeat_pulse;
  logic          any_press;

  always #5 clk = ~clk;

  btn_debounce_bank #(
    .CHANNELS(CH), .CNT_DEPTH(CD), .POLARITY(POL),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .resetn(resetn), .raw_in(raw_in),
    .level(level), .press(press), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .any_press(any_press)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: raw samples per edge, window of normalised inputs, expected outputs.
  int         cyc;
  logic [1:0] samp_q[$];
  logic [1:0] nwin[$];
  logic [1:0] m_level, m_press, m_rel, m_rep;
  logic       m_any;
  int         press_cyc[CH];

  // Observed-event bookkeeping for the directed checks.
  int last_press_seen[CH], last_rel_seen[CH], n_press_seen[CH];
  int n_any_seen;
  int rep_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    samp_q = {POL, POL};
    nwin.delete();
    m_level = '0; m_press = '0; m_rel = '0; m_rep = '0; m_any = 1'b0;
    for (int c = 0; c < CH; c++) press_cyc[c] = -1;
    cyc = 0;
  endtask

  task automatic check_outputs(input string phase);
    check({phase, ".level"},   {6'd0, level},         {6'd0, m_level});
    check({phase, ".press"},   {6'd0, press},         {6'd0, m_press});
    check({phase, ".release"}, {6'd0, release_pulse}, {6'd0, m_rel});
    check({phase, ".repeat"},  {6'd0, repeat_pulse},  {6'd0, m_rep});
    check({phase, ".any"},     {7'd0, any_press},     {7'd0, m_any});
  endtask

  // One clock: drive pins, let the edge sample them, advance the model, compare.
  task automatic step(input logic [1:0] r);
    logic [1:0] n_now;
    logic       all_differ;
    int         d;
    raw_in = r;
    @(posedge clk);
    cyc++;
    samp_q.push_back(r);
    n_now = samp_q[samp_q.size() - 3] ^ POL;   // sample taken two edges earlier
    if (samp_q.size() > 3) void'(samp_q.pop_front());
    nwin.push_back(n_now);
    if (nwin.size() > CD) void'(nwin.pop_front());
    m_press = '0; m_rel = '0; m_rep = '0;
    for (int c = 0; c < CH; c++) begin
      all_differ = (nwin.size() == CD);
      for (int j = 0; j < nwin.size(); j++)
        if (nwin[j][c] == m_level[c]) all_differ = 1'b0;
      if (all_differ) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin m_press[c] = 1'b1; press_cyc[c] = cyc; end
        else            begin m_rel[c]   = 1'b1; press_cyc[c] = -1;  end
      end
`ifdef BTN_REPEAT_EN
      else if (m_level[c] && press_cyc[c] >= 0) begin
        d = cyc - press_cyc[c];
        if (d >= RD && (d - RD) % RP == 0) m_rep[c] = 1'b1;
      end
`endif
    end
    m_any = |m_press;
    #1;
    check_outputs("step");
    for (int c = 0; c < CH; c++) begin
      if (press[c])         begin n_press_seen[c]++; last_press_seen[c] = cyc; end
      if (release_pulse[c]) last_rel_seen[c] = cyc;
    end
    if (any_press)       n_any_seen++;
    if (repeat_pulse[0]) rep_q.push_back(cyc);
  endtask

  task automatic run(input logic [1:0] r, input int n);
    for (int k = 0; k < n; k++) step(r);
  endtask

  initial begin
    int c0, any0, np0;
    for (int c = 0; c < CH; c++) begin
      last_press_seen[c] = -1; last_rel_seen[c] = -1; n_press_seen[c] = 0;
    end
    n_any_seen = 0;
    model_reset();

    // Reset with raw idle (ch1 active-low idles high).
    raw_in = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("in_reset");
    resetn = 1'b1;
    model_reset();
    run(2'b10, 20);
    check("reset_quiet_press", 8'(n_press_seen[0] + n_press_seen[1]), 8'd0);
    check("reset_quiet_any", 8'(n_any_seen), 8'd0);

    // Clean press and release on ch0.
    c0 = cyc;
    run(2'b11, 10);
    check("press_latency", 8'(last_press_seen[0] - c0), 8'd6);
    check("press_any", 8'(n_any_seen), 8'd1);
    c0 = cyc;
    run(2'b10, 10);
    check("release_latency", 8'(last_rel_seen[0] - c0), 8'd6);

    // Glitch rejection: 3 cycles discarded, 4 cycles accepted.
    np0 = n_press_seen[0];
    run(2'b11, 3);
    run(2'b10, 10);
    check("glitch3_press", 8'(n_press_seen[0] - np0), 8'd0);
    check("glitch3_level", {7'd0, level[0]}, 8'd0);
    run(2'b11, 4);
    run(2'b10, 10);
    check("pulse4_press", 8'(n_press_seen[0] - np0), 8'd1);

    // Simultaneous press of ch0 (active-high) and ch1 (active-low).
    c0 = cyc; any0 = n_any_seen;
    run(2'b01, 10);
    check("simul_ch0", 8'(last_press_seen[0] - c0), 8'd6);
    check("simul_ch1", 8'(last_press_seen[1] - c0), 8'd6);
    check("simul_any_once", 8'(n_any_seen - any0), 8'd1);

    // Reset mid-debounce: ch1 held, ch0 pending with counter at 2.
    run(2'b00, 10);
    run(2'b01, 4);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_level", {6'd0, level}, 8'd0);
    check("async_reset_press", {6'd0, press}, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_level", {6'd0, level}, 8'd0);
    resetn = 1'b1;
    model_reset();
    c0 = cyc;
    for (int c = 0; c < CH; c++) last_press_seen[c] = -1;
    run(2'b01, 5);
    check("post_reset_wait", {6'd0, level}, 8'd0);
    run(2'b01, 5);
    check("post_reset_ch0", 8'(last_press_seen[0] - c0), 8'd6);
    check("post_reset_ch1", 8'(last_press_seen[1] - c0), 8'd6);
    run(2'b10, 12);

    // Long hold on ch0: repeats every RP after the first at RD.
    rep_q.delete();
    c0 = cyc;
    while (cyc < c0 + 26) step(2'b11);
    run(2'b10, 12);
`ifdef BTN_REPEAT_EN
    check("rep_long_count", 8'(rep_q.size()), 8'd6);
    if (rep_q.size() >= 3) begin
      check("rep_first",  8'(rep_q[0] - (c0 + 6)), 8'd8);
      check("rep_second", 8'(rep_q[1] - (c0 + 6)), 8'd11);
      check("rep_third",  8'(rep_q[2] - (c0 + 6)), 8'd14);
    end
`else
    check("rep_off_long", 8'(rep_q.size()), 8'd0);
`endif

    // Hold ending with the release edge at press+12: nothing at +14.
    rep_q.delete();
    c0 = cyc;
    while (cyc < c0 + 12) step(2'b11);
    run(2'b10, 12);
    check("rep_release_edge", 8'(last_rel_seen[0] - (c0 + 6)), 8'd12);
`ifdef BTN_REPEAT_EN
    check("rep_short_count", 8'(rep_q.size()), 8'd2);
`else
    check("rep_off_short", 8'(rep_q.size()), 8'd0);
`endif

    // Random pin activity with random hold lengths, model-checked every cycle.
    for (int k = 0; k < 150; k++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      run(r, $urandom_range(1, 12));
    end
    run(2'b10, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
